tone_square_out: RTL and testbench
==================================

Name: tone_square_out

Overview:
- Downstream consumer of the `music` note selector's 23-bit `sound` word. That word is a half-period count in `clk` cycles, and 0 means rest.
- Produces a glitch-free square wave on the speaker/PWM audio pin.
- Period changes are taken only at waveform edges, so no runt pulses appear when the melody advances.

Parameters:
- PERIOD_W, 23, width of the half-period word; matches `sound`.
- VOL_W, 3, volume word width; used only when TONE_VOLUME_EN is defined.

Ports:
- clk  input  1  system clock (100 MHz board clock)
- reset  input  1  synchronous, active-high reset
- enable  input  1  audio enable; low forces silence
- period_in  input  PERIOD_W  half-period in clk cycles from `music.sound`; 0 means rest
- speaker_out  output  1  square-wave audio pin
- note_active  output  1  high while a tone is being generated (state RUN)
- edge_pulse  output  1  one-cycle strobe on every toggle of the wave
- vol  input  VOL_W  volume level; present only with TONE_VOLUME_EN

Behaviour:
- One clock (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - speaker_out=0, note_active=0, edge_pulse=0.
  - Internal: cnt=0, per_lat=0, wave=0, state=IDLE.
- States:
  - IDLE: no tone.
  - RUN: tone in progress.
- IDLE, at each edge:
  - If enable=1 and period_in!=0: per_lat<=period_in, cnt<=period_in-1, wave<=1, edge_pulse<=1, state<=RUN.
  - First high level is visible the cycle after period_in becomes nonzero.
  - Otherwise wave stays 0.
- RUN, at each edge:
  - enable=0 takes priority over all RUN rules: wave<=0, cnt<=0, per_lat<=0, state<=IDLE, no edge_pulse. This applies in the same cycle as any terminal count.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0 (terminal) and period_in!=0: wave<=~wave, per_lat<=period_in, cnt<=period_in-1, edge_pulse<=1.
  - cnt==0 and period_in==0: wave<=0, state<=IDLE. edge_pulse<=1 only if wave was 1.
- Each phase (high or low) lasts exactly per_lat cycles, so the full period is 2×P.
- A period_in change mid-phase has no effect until the current phase ends. The next phase uses the new value.
- period_in=1 gives a toggle every cycle (frequency clk/2). This is the legal minimum; no clamping.
- period_in is sampled only at terminal count or in IDLE. No width arithmetic beyond PERIOD_W; cnt is PERIOD_W wide.
- Without the optional feature, speaker_out = wave.
- note_active = (state==RUN).
- edge_pulse is registered, high exactly one cycle per toggle.
- Reset mid-tone: back to reset values on the next edge regardless of state. There is no drain.

Optional Feature:
- Macro: TONE_VOLUME_EN.
- Defined:
  - Adds the `vol` port and a free-running VOL_W-bit counter pcnt (reset 0, increments every cycle).
  - speaker_out = wave & (pcnt < vol), registered one cycle later than wave, so everything is shifted one cycle.
  - vol=0 gives silence. vol=2^VOL_W-1 gives 7/8 duty during the high phase.
  - note_active and edge_pulse are unaffected.
- Undefined:
  - No `vol` port, no pcnt.
  - speaker_out = wave, combinational from the wave register, with zero added latency.

Decomposition:
- Package tone_pkg holds:
  - PERIOD_W=23 and VOL_W=3 defaults.
  - Constant REST_PERIOD=23'd0.
  - State encoding typedef tone_state_t {IDLE, RUN}.
- One natural sub-module: tone_vol_pwm. It contains pcnt, the compare and the output register, and is instantiated only under TONE_VOLUME_EN.

Test Plan:
- **Start-up and steady tone:** reset 4 cycles, enable=1, period_in=5 → speaker_out goes high 1 cycle later; it stays high 5 cycles, low 5, high 5. edge_pulse fires every 5 cycles; note_active=1.
- **Minimum period:** period_in=1 → speaker_out toggles every cycle; edge_pulse is constantly 1 after start.
- **Glitch-free retune:** period_in=4, change to 10 two cycles into a high phase → that high phase still lasts 4 cycles; the next low phase lasts 10.
- **Rest:** period_in=6, drive 0 mid-low-phase → phase completes (6 cycles low), state returns to IDLE, note_active=0, no edge_pulse. Driving 0 mid-high-phase instead gives a falling edge with edge_pulse at the terminal count.
- **Enable and reset abort:** enable=0 mid-phase → speaker_out=0 and note_active=0 the next cycle. reset=1 mid-phase → all outputs 0 the next cycle. A restart after either behaves like start-up.
- **TONE_VOLUME_EN:** period_in=16, vol=2 → within each high phase speaker_out is high on pcnt=0,1 of every 8 cycles, one cycle delayed. vol=0 → speaker_out constantly 0 while edge_pulse still fires.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared widths, the rest code and the tone FSM state encoding for the
// square-wave tone generator.
package tone_pkg;

    localparam int PERIOD_W_DEF = 23;
    localparam int VOL_W_DEF    = 3;

    localparam logic [PERIOD_W_DEF-1:0] REST_PERIOD = 23'd0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tone_state_t;

endpackage

// File: rtl/tone_vol_pwm.sv
// Volume gate for the tone output: a free-running duty counter chops the high
// phase of the wave. Built only when TONE_VOLUME_EN is defined.
module tone_vol_pwm
    import tone_pkg::*;
#(
    parameter int VOL_W = VOL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wave,
    input  logic [VOL_W-1:0] i_vol,
    output logic             o_pwm
);

    logic [VOL_W-1:0] r_pcnt;
    logic             r_pwm;
    logic             w_duty_on;

    // vol=0 never passes; the all-ones code passes all but one slot in 2^VOL_W.
    assign w_duty_on = (r_pcnt < i_vol);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_pcnt <= r_pcnt + VOL_W'(1);
            r_pwm  <= i_wave & w_duty_on;
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/tone_square_out.sv
// Square-wave tone generator driven by a half-period word (0 = rest).
// Optional TONE_VOLUME_EN adds a vol port and a PWM volume gate on the output.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no tone, wave held low, waiting for a nonzero period
//   RUN   | tone in progress, cnt counts down the current phase
module tone_square_out
    import tone_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
`ifdef TONE_VOLUME_EN
    ,
    parameter int VOL_W    = VOL_W_DEF
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period_in,
`ifdef TONE_VOLUME_EN
    input  logic [VOL_W-1:0]    vol,
`endif
    output logic                speaker_out,
    output logic                note_active,
    output logic                edge_pulse
);

    tone_state_t         r_state;
    tone_state_t         w_state_nxt;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_nxt;
    logic                r_wave;
    logic                w_wave_nxt;
    logic                r_edge;
    logic                w_edge_nxt;

    logic                w_tone_req;
    logic                w_tc;
    logic [PERIOD_W-1:0] w_reload;

    assign w_tone_req = (period_in != PERIOD_W'(REST_PERIOD));
    assign w_tc       = (r_cnt == '0);
    // The phase includes the cycle in which it is loaded, hence the minus one.
    assign w_reload   = period_in - PERIOD_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wave  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wave  <= w_wave_nxt;
            r_edge  <= w_edge_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wave_nxt  = r_wave;
        w_edge_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_wave_nxt = 1'b0;
                w_cnt_nxt  = '0;
                if (enable && w_tone_req) begin
                    w_cnt_nxt   = w_reload;
                    w_wave_nxt  = 1'b1;
                    w_edge_nxt  = 1'b1;
                    w_state_nxt = RUN;
                end
            end

            RUN: begin
                // Dropping enable wins even over a terminal count: silent, no strobe.
                if (!enable) begin
                    w_wave_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (!w_tc) begin
                    w_cnt_nxt = r_cnt - PERIOD_W'(1);
                end else if (w_tone_req) begin
                    w_wave_nxt = ~r_wave;
                    w_cnt_nxt  = w_reload;
                    w_edge_nxt = 1'b1;
                end else begin
                    w_wave_nxt  = 1'b0;
                    w_edge_nxt  = r_wave;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_wave_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign note_active = (r_state == RUN);
    assign edge_pulse  = r_edge;

`ifdef TONE_VOLUME_EN
    tone_vol_pwm #(
        .VOL_W (VOL_W)
    ) u_vol_pwm (
        .clk    (clk),
        .reset  (reset),
        .i_wave (r_wave),
        .i_vol  (vol),
        .o_pwm  (speaker_out)
    );
`else
    assign speaker_out = r_wave;
`endif

endmodule

// File: tb/tb_tone_square_out.sv
// Self-checking bench for tone_square_out (default build, no volume gate):
// directed scenarios followed by randomized period/enable/reset traffic.
module tb_tone_square_out;

    localparam int PW = 23;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [PW-1:0] period_in;
    logic          speaker_out;
    logic          note_active;
    logic          edge_pulse;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: the tone as a sequence of phases, each with a length
    // and an age (cycles already shown, counting up from 1).
    bit m_run  = 0;
    bit m_lvl  = 0;
    bit m_edge = 0;
    int m_len  = 0;
    int m_age  = 0;

    // Directed measurements
    int hi_len;
    int lo_len;

    tone_square_out dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period_in   (period_in),
        .speaker_out (speaker_out),
        .note_active (note_active),
        .edge_pulse  (edge_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // One clock: advance the model with the inputs seen at this edge, then
    // compare all outputs shortly after the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_lvl = 0; m_edge = 0; m_len = 0; m_age = 0;
        end else if (!m_run) begin
            if (enable && period_in != 0) begin
                m_run = 1; m_lvl = 1; m_edge = 1;
                m_len = int'(period_in); m_age = 1;
            end else begin
                m_lvl = 0; m_edge = 0;
            end
        end else if (!enable) begin
            m_run = 0; m_lvl = 0; m_edge = 0;
        end else if (m_age < m_len) begin
            m_age++;
            m_edge = 0;
        end else if (period_in != 0) begin
            m_lvl = !m_lvl; m_edge = 1;
            m_len = int'(period_in); m_age = 1;
        end else begin
            m_edge = m_lvl;
            m_lvl  = 0;
            m_run  = 0;
        end
        #1;
        chk("speaker_out", speaker_out, m_lvl);
        chk("note_active", note_active, m_run);
        chk("edge_pulse",  edge_pulse,  m_edge);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        period_in = '0;

        // Start-up and steady tone
        ticks(4);
        chk("reset_speaker", speaker_out, 1'b0);
        chk("reset_active",  note_active, 1'b0);
        chk("reset_edge",    edge_pulse,  1'b0);
        reset     = 1'b0;
        enable    = 1'b1;
        period_in = 23'd5;
        tick();
        chk("startup_high", speaker_out, 1'b1);
        ticks(24);

        // Minimum period: toggles every cycle
        period_in = 23'd1;
        ticks(12);

        // Glitch-free retune: wait for a rising edge at period 4, then retune
        period_in = 23'd4;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (edge_pulse && speaker_out && m_len == 4) break;
        end
        chk("retune_sync", speaker_out, 1'b1);
        tick();
        period_in = 23'd10;
        hi_len = 2;
        for (int i = 0; i < 20 && speaker_out; i++) begin
            tick();
            if (speaker_out) hi_len++;
        end
        chk_int("retune_high_len", hi_len, 4);
        lo_len = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (speaker_out) break;
            lo_len++;
        end
        chk_int("retune_low_len", lo_len, 10);

        // Rest mid-low phase: phase finishes, then IDLE without a strobe
        period_in = 23'd6;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (edge_pulse && !speaker_out) break;
        end
        ticks(2);
        period_in = 23'd0;
        ticks(6);
        chk("rest_low_idle", note_active, 1'b0);
        chk("rest_low_noedge", edge_pulse, 1'b0);

        // Rest mid-high phase: falling edge with a strobe at terminal count
        period_in = 23'd6;
        ticks(3);
        period_in = 23'd0;
        ticks(4);
        chk("rest_high_edge", edge_pulse, 1'b1);
        chk("rest_high_idle", note_active, 1'b0);
        ticks(2);

        // Enable abort mid-phase, then restart
        period_in = 23'd7;
        ticks(4);
        enable = 1'b0;
        tick();
        chk("en_abort_spk", speaker_out, 1'b0);
        ticks(2);
        enable = 1'b1;
        ticks(16);

        // Reset abort mid-phase, then restart
        reset = 1'b1;
        tick();
        chk("rst_abort_spk", speaker_out, 1'b0);
        reset = 1'b0;
        ticks(16);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) period_in = PW'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
